usb_ep_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single packet-engine endpoint buffer between NUM_EPS endpoint requesters (control EP, serial bridge EP, future EPs) via one-hot req/grant.
- Holds a grant for the whole transfer, never re-arbitrates while the packet engine is mid-packet, and recovers from a stuck requester with a watchdog.
- Instantiated once per direction (OUT and IN) between the endpoint blocks and the USB protocol engine, all on clk (48 MHz).

---
 rtl/usb_arb_pkg.sv | 44 ++++
 rtl/usb_rr_pick.sv | 23 ++
 rtl/usb_ep_rr_arbiter.sv | 109 ++++++++++
 tb/tb_usb_ep_rr_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_arb_pkg.sv
// Shared types and the round-robin pick helper for the endpoint buffer arbiters.
// rr_pick is written for up to MAX_EPS requesters; callers zero-extend req and ptr.
package usb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam int DEFAULT_WATCHDOG = 65535;
  localparam int MAX_EPS          = 16;
  localparam int IDX_W_MAX        = 4;

  typedef struct packed {
    logic [IDX_W_MAX-1:0] idx;
    logic                 found;
  } pick_t;

  // Rotate so ptr lands on bit 0, take the lowest set bit, rotate the index back.
  // Assumes ptr < n and req bits at or above n are zero.
  function automatic pick_t rr_pick(input logic [MAX_EPS-1:0]   req,
                                    input logic [IDX_W_MAX-1:0] ptr,
                                    input int                   n);
    logic [2*MAX_EPS-1:0] dbl;
    logic [2*MAX_EPS-1:0] rot;
    logic [IDX_W_MAX:0]   sum;
    pick_t                r;
    r   = '0;
    sum = '0;
    dbl = {{MAX_EPS{1'b0}}, req} | ({{MAX_EPS{1'b0}}, req} << n);
    rot = dbl >> ptr;
    for (int j = MAX_EPS - 1; j >= 0; j--) begin
      if (j < n && rot[j]) begin
        sum = {1'b0, ptr} + (IDX_W_MAX+1)'(j);
        if (int'(sum) >= n) sum = sum - (IDX_W_MAX+1)'(n);
        r.idx   = sum[IDX_W_MAX-1:0];
        r.found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/usb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod N.
// Shared with the packet engine's own arbitration.
module usb_rr_pick
  import usb_arb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  pick_t p;
  logic  unused_idx;

  assign p          = rr_pick(MAX_EPS'(req), IDX_W_MAX'(ptr), N);
  assign idx        = p.idx[$clog2(N)-1:0];
  assign found      = p.found;
  // Upper index bits are always zero for N below MAX_EPS.
  assign unused_idx = ^p.idx;

endmodule

// File: rtl/usb_ep_rr_arbiter.sv
// Round-robin arbiter sharing the packet-engine endpoint buffer between endpoint requesters.
// state   | meaning
// IDLE    | no grant; arbitrate from ptr when any request is up
// GRANT   | grant_idx owns the buffer; watchdog counts unlocked cycles
// RELEASE | single dead cycle; ptr already advanced, next owner picked here
module usb_ep_rr_arbiter
  import usb_arb_pkg::*;
#(
  parameter int NUM_EPS  = 3,
  parameter int WATCHDOG = DEFAULT_WATCHDOG,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_EPS-1:0]         ep_req,
  input  logic                       xfer_lock,
  output logic [NUM_EPS-1:0]         ep_grant,
  output logic                       grant_valid,
  output logic [$clog2(NUM_EPS)-1:0] grant_idx,
  output logic                       wd_timeout
);

  localparam int IW = $clog2(NUM_EPS);

  arb_state_e         state, state_n;
  logic [IW-1:0]      ptr, ptr_n, idx_n, pick_idx, ptr_after;
  logic               pick_found, valid_n, wd_n, wd_expired;
  logic [NUM_EPS-1:0] grant_n;
  logic [CNT_W-1:0]   wd_cnt, cnt_n;

  usb_rr_pick #(.N(NUM_EPS)) u_pick (
    .req   (ep_req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign wd_expired = (WATCHDOG != 0) && (wd_cnt == CNT_W'(WATCHDOG));
  assign ptr_after  = (grant_idx == IW'(NUM_EPS - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    grant_n = ep_grant;
    idx_n   = grant_idx;
    valid_n = grant_valid;
    wd_n    = 1'b0;
    cnt_n   = wd_cnt;
    case (state)
      IDLE, RELEASE: begin
        state_n = IDLE;
        grant_n = '0;
        valid_n = 1'b0;
        if (pick_found) begin
          state_n = GRANT;
          grant_n = NUM_EPS'(1) << pick_idx;
          idx_n   = pick_idx;
          valid_n = 1'b1;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        // A dropped request wins over a coincident watchdog expiry.
        if (!ep_req[grant_idx]) begin
          if (!xfer_lock) begin
            state_n = RELEASE;
            grant_n = '0;
            valid_n = 1'b0;
            ptr_n   = ptr_after;
          end
        end else if (wd_expired) begin
          state_n = RELEASE;
          grant_n = '0;
          valid_n = 1'b0;
          ptr_n   = ptr_after;
          wd_n    = 1'b1;
        end else if (!xfer_lock && (WATCHDOG != 0)) begin
          cnt_n = wd_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      ep_grant    <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      wd_timeout  <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      ep_grant    <= grant_n;
      grant_valid <= valid_n;
      grant_idx   <= idx_n;
      wd_timeout  <= wd_n;
      wd_cnt      <= cnt_n;
    end
  end

endmodule

// File: tb/tb_usb_ep_rr_arbiter.sv
// Self-checking bench for usb_ep_rr_arbiter: vector table, directed corner sequences,
// and randomized traffic against a cycle-level reference of the arbitration rules.
module tb_usb_ep_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst3, lock3, val3, wdt3;
  logic [2:0] req3, gnt3;
  logic [1:0] idx3;
  logic       rst5, lock5, val5, wdt5;
  logic [4:0] req5, gnt5;
  logic [2:0] idx5;

  usb_ep_rr_arbiter #(.NUM_EPS(3), .WATCHDOG(8), .CNT_W(4)) u_d3 (
    .clk(clk), .reset(rst3), .ep_req(req3), .xfer_lock(lock3),
    .ep_grant(gnt3), .grant_valid(val3), .grant_idx(idx3), .wd_timeout(wdt3)
  );

  usb_ep_rr_arbiter #(.NUM_EPS(5), .WATCHDOG(0), .CNT_W(16)) u_d5 (
    .clk(clk), .reset(rst5), .ep_req(req5), .xfer_lock(lock5),
    .ep_grant(gnt5), .grant_valid(val5), .grant_idx(idx5), .wd_timeout(wdt5)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic       lock;
    logic [2:0] gnt;
    logic [1:0] idx;
    logic       wdt;
  } vec_t;
  vec_t tbl[$];

  // owner = -1 when no grant; age = unlocked cycles since the grant appeared
  typedef struct {
    int owner;
    int ptr;
    int age;
    int last;
    bit wdt;
  } mdl_t;

  task automatic add(logic rst, logic [2:0] req, logic lock, logic [2:0] gnt,
                     logic [1:0] idx, logic wdt);
    vec_t v;
    v.rst = rst; v.req = req; v.lock = lock; v.gnt = gnt; v.idx = idx; v.wdt = wdt;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mdl_t mstep(mdl_t m, int n, int wd, logic [15:0] req, bit lock, bit rst);
    mdl_t r;
    bit   found;
    r     = m;
    r.wdt = 1'b0;
    found = 1'b0;
    if (rst) begin
      r.owner = -1; r.ptr = 0; r.age = 0; r.last = 0;
    end else if (m.owner < 0) begin
      for (int k = 0; k < n; k++) begin
        if (!found && req[(m.ptr + k) % n]) begin
          found   = 1'b1;
          r.owner = (m.ptr + k) % n;
          r.last  = r.owner;
          r.age   = 0;
        end
      end
    end else if (!req[m.owner]) begin
      if (!lock) begin
        r.owner = -1;
        r.ptr   = (m.owner + 1) % n;
      end
    end else if (wd != 0 && m.age == wd) begin
      r.owner = -1;
      r.ptr   = (m.owner + 1) % n;
      r.wdt   = 1'b1;
    end else if (!lock) begin
      r.age = m.age + 1;
    end
    return r;
  endfunction

  task automatic chk_mdl(string tag, int cyc, logic [15:0] g, logic v, logic [3:0] i,
                         logic w, mdl_t m);
    logic [15:0] eg;
    logic        ev;
    eg = (m.owner >= 0) ? (16'(1) << m.owner) : 16'h0;
    ev = (m.owner >= 0);
    n_tests++;
    if (g !== eg || v !== ev || i !== 4'(m.last) || w !== m.wdt) begin
      n_fail++;
      $display("FAIL %s cycle %0d: grant=%h valid=%b idx=%0d wd=%b expected grant=%h valid=%b idx=%0d wd=%b",
               tag, cyc, g, v, i, w, eg, ev, m.last, m.wdt);
    end
  endtask

  initial begin
    mdl_t m3, m5;

    // single requester, wrap from ptr=2, fairness 0,1,2,0,1
    add(1, 3'b000, 0, 3'b000, 0, 0);
    for (int k = 0; k < 5; k++) add(0, 3'b010, 0, 3'b010, 1, 0);
    add(0, 3'b000, 0, 3'b000, 1, 0);
    add(0, 3'b000, 0, 3'b000, 1, 0);
    add(0, 3'b011, 0, 3'b001, 0, 0);
    add(0, 3'b011, 0, 3'b001, 0, 0);
    add(0, 3'b010, 0, 3'b000, 0, 0);
    add(0, 3'b010, 0, 3'b010, 1, 0);
    add(0, 3'b000, 0, 3'b000, 1, 0);
    add(1, 3'b000, 0, 3'b000, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 3'b111, 0, 3'b001, 0, 0);
    add(0, 3'b110, 0, 3'b000, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 3'b111, 0, 3'b010, 1, 0);
    add(0, 3'b101, 0, 3'b000, 1, 0);
    for (int k = 0; k < 4; k++) add(0, 3'b111, 0, 3'b100, 2, 0);
    add(0, 3'b011, 0, 3'b000, 2, 0);
    for (int k = 0; k < 4; k++) add(0, 3'b111, 0, 3'b001, 0, 0);
    add(0, 3'b110, 0, 3'b000, 0, 0);
    add(0, 3'b111, 0, 3'b010, 1, 0);
    add(0, 3'b101, 0, 3'b000, 1, 0);
    add(0, 3'b000, 0, 3'b000, 1, 0);

    rst5 = 1'b1; req5 = '0; lock5 = 1'b0;
    foreach (tbl[r]) begin
      rst3 = tbl[r].rst; req3 = tbl[r].req; lock3 = tbl[r].lock;
      tick();
      chk($sformatf("tbl%0d_grant", r), 32'(gnt3), 32'(tbl[r].gnt));
      chk($sformatf("tbl%0d_valid", r), 32'(val3), 32'(|tbl[r].gnt));
      chk($sformatf("tbl%0d_idx", r),   32'(idx3), 32'(tbl[r].idx));
      chk($sformatf("tbl%0d_wd", r),    32'(wdt3), 32'(tbl[r].wdt));
    end

    // lock hold: ptr=2, EP0 granted, req drops at cycle 3, lock falls at cycle 10
    rst3 = 1'b0; req3 = 3'b001; lock3 = 1'b0;
    tick(); chk("lock_grant", 32'(gnt3), 32'h1);
    for (int c = 1; c <= 9; c++) begin
      req3  = (c < 3) ? 3'b001 : 3'b000;
      lock3 = 1'b1;
      tick(); chk($sformatf("lock_hold%0d", c), 32'(gnt3), 32'h1);
    end
    req3 = 3'b000; lock3 = 1'b0;
    tick(); chk("lock_release", 32'(gnt3), 32'h0);
    tick(); chk("lock_idle", 32'(gnt3), 32'h0);

    // watchdog: ptr=1, EP2 and EP0 requesting, EP2 never lets go
    req3 = 3'b101;
    for (int k = 0; k <= 8; k++) begin
      tick();
      chk($sformatf("wd_hold%0d", k), 32'(gnt3), 32'h4);
      chk($sformatf("wd_quiet%0d", k), 32'(wdt3), 32'h0);
    end
    tick();
    chk("wd_drop", 32'(gnt3), 32'h0);
    chk("wd_pulse", 32'(wdt3), 32'h1);
    tick();
    chk("wd_next_ep0", 32'(gnt3), 32'h1);
    chk("wd_pulse_end", 32'(wdt3), 32'h0);
    for (int k = 11; k <= 18; k++) tick();
    chk("wd_ep0_still", 32'(gnt3), 32'h1);
    req3 = 3'b100;
    tick();
    chk("wd_coincide_drop", 32'(gnt3), 32'h0);
    chk("wd_coincide_nopulse", 32'(wdt3), 32'h0);
    req3 = 3'b000;
    tick();

    // reset while locked mid-grant
    req3 = 3'b010; lock3 = 1'b0;
    tick(); chk("rst_pre_grant", 32'(gnt3), 32'h2);
    lock3 = 1'b1;
    tick(); tick(); chk("rst_pre_hold", 32'(gnt3), 32'h2);
    rst3 = 1'b1;
    tick();
    chk("rst_grant", 32'(gnt3), 32'h0);
    chk("rst_valid", 32'(val3), 32'h0);
    chk("rst_idx", 32'(idx3), 32'h0);
    chk("rst_ptr", 32'(u_d3.ptr), 32'h0);
    rst3 = 1'b0; req3 = 3'b110; lock3 = 1'b0;
    tick();
    chk("rst_after_grant", 32'(gnt3), 32'h2);
    chk("rst_after_idx", 32'(idx3), 32'h1);
    req3 = 3'b000;
    tick();

    // NUM_EPS=5: reach ptr=4, EP4 beats EP0, then 4 wraps to 0
    rst5 = 1'b0; req5 = 5'b01000;
    tick(); chk("n5_ep3", 32'(idx5), 32'h3);
    req5 = 5'b00000;
    tick(); chk("n5_rel", 32'(gnt5), 32'h0);
    tick();
    req5 = 5'b10001;
    tick();
    chk("n5_ep4_grant", 32'(gnt5), 32'h10);
    chk("n5_ep4_idx", 32'(idx5), 32'h4);
    req5 = 5'b00001;
    tick(); chk("n5_ep4_rel", 32'(gnt5), 32'h0);
    req5 = 5'b00011;
    tick();
    chk("n5_wrap_grant", 32'(gnt5), 32'h1);
    chk("n5_wrap_idx", 32'(idx5), 32'h0);
    for (int k = 0; k < 30; k++) tick();
    chk("n5_no_watchdog", 32'(gnt5), 32'h1);
    chk("n5_no_pulse", 32'(wdt5), 32'h0);
    req5 = 5'b00000;
    tick();
    chk("n5_idx_hold", 32'(idx5), 32'h0);

    // randomized traffic against the reference
    m3 = '{owner: -1, ptr: 0, age: 0, last: 0, wdt: 1'b0};
    m5 = m3;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int b = 0; b < 3; b++) if ($urandom_range(7) == 0) req3[b] = ~req3[b];
      for (int b = 0; b < 5; b++) if ($urandom_range(7) == 0) req5[b] = ~req5[b];
      if ($urandom_range(5) == 0) lock3 = ~lock3;
      if ($urandom_range(5) == 0) lock5 = ~lock5;
      rst3 = (cyc == 0) || ($urandom_range(299) == 0);
      rst5 = (cyc == 0) || ($urandom_range(299) == 0);
      m3 = mstep(m3, 3, 8, {13'b0, req3}, lock3, rst3);
      m5 = mstep(m5, 5, 0, {11'b0, req5}, lock5, rst5);
      tick();
      chk_mdl("rnd3", cyc, {13'b0, gnt3}, val3, {2'b0, idx3}, wdt3, m3);
      chk_mdl("rnd5", cyc, {11'b0, gnt5}, val5, {1'b0, idx5}, wdt5, m5);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
